// File: rtl/mc_mem_if.sv
// mc_mem_if: turns multicycle FSM memory strobes into one req/ack bus transaction, stalling the core.
// Owns Instr, OldPC and ReadData, plus store lane steering and load extraction/extension.
module mc_mem_if #(
    parameter int              XLEN      = 32,
    parameter int              TIMEOUT   = 16,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            IRWrite,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            AdrSrc,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] Result,
    input  logic [XLEN-1:0] WriteData,
    output logic            Stall,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] OldPC,
    output logic [XLEN-1:0] ReadData,
    output logic            MisalignErr,
    output logic            BusErr,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack
);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
    localparam logic [1:0] K_FETCH = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2;
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]      r_state, r_kind, r_off;
    logic [2:0]      r_f3;
    logic [CW-1:0]   r_cnt;
    logic            w_strobe, w_byte, w_half, w_misal;
    logic [1:0]      w_off;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_addr, w_wdata, w_ext;
    logic [7:0]      w_rbyte;
    logic [15:0]     w_rhalf;

    assign w_strobe = IRWrite | MemRead | MemWrite;
    assign w_addr   = (IRWrite | ~AdrSrc) ? PC : Result;
    assign w_off    = w_addr[1:0];
    // Fetches are always word accesses whatever Funct3 happens to hold.
    assign w_byte   = ~IRWrite & (Funct3[1:0] == 2'b00);
    assign w_half   = ~IRWrite & (Funct3[1:0] == 2'b01);
    assign w_misal  = w_byte ? 1'b0 : w_half ? w_off[0] : |w_off;
    assign w_be     = ~MemWrite ? 4'b1111 : w_byte ? 4'b0001 << w_off : w_half ? 4'b0011 << w_off : 4'b1111;
    assign w_wdata  = w_byte ? {(XLEN/8){WriteData[7:0]}} : w_half ? {(XLEN/16){WriteData[15:0]}} : WriteData;
    assign w_rbyte  = mem_rdata[{r_off, 3'b000} +: 8];
    assign w_rhalf  = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign w_ext    = r_f3 == 3'b000 ? {{(XLEN-8){w_rbyte[7]}}, w_rbyte} :
                      r_f3 == 3'b100 ? {{(XLEN-8){1'b0}}, w_rbyte} :
                      r_f3 == 3'b001 ? {{(XLEN-16){w_rhalf[15]}}, w_rhalf} :
                      r_f3 == 3'b101 ? {{(XLEN-16){1'b0}}, w_rhalf} : mem_rdata;
    assign Stall    = w_strobe & (r_state != S_DONE);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_kind      <= K_FETCH;
            r_off       <= 2'b00;
            r_f3        <= 3'b000;
            r_cnt       <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 4'b0000;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            Instr       <= NOP_INSTR;
            OldPC       <= '0;
            ReadData    <= '0;
            BusErr      <= 1'b0;
            MisalignErr <= 1'b0;
        end else begin
            MisalignErr <= 1'b0;
            if (r_state == S_IDLE && w_strobe) begin
                if (w_misal) begin
                    r_state     <= S_DONE;
                    MisalignErr <= 1'b1;
                end else begin
                    r_state   <= S_BUSY;
                    r_kind    <= IRWrite ? K_FETCH : MemRead ? K_LOAD : K_STORE;
                    r_off     <= w_off;
                    r_f3      <= Funct3;
                    r_cnt     <= '0;
                    mem_req   <= 1'b1;
                    mem_we    <= MemWrite & ~IRWrite;
                    mem_be    <= w_be;
                    mem_addr  <= {w_addr[XLEN-1:2], 2'b00};
                    mem_wdata <= w_wdata;
                end
            end else if (r_state == S_BUSY) begin
                if (mem_ack) begin
                    r_state <= S_DONE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    if (r_kind == K_FETCH) begin
                        Instr <= mem_rdata;
                        OldPC <= PC;
                    end
                    if (r_kind == K_LOAD)
                        ReadData <= w_ext;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    r_state <= S_DONE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    BusErr  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_state == S_DONE) begin
                r_state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mc_mem_if.sv
// tb_mc_mem_if: table-driven check of mc_mem_if transactions plus timeout and reset-in-BUSY sequences.
module tb_mc_mem_if;
    logic        CLK = 1'b0, Reset = 1'b1;
    logic        IRWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, AdrSrc = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] PC = '0, Result = '0, WriteData = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        Stall, MisalignErr, BusErr, mem_req, mem_we;
    logic [31:0] Instr, OldPC, ReadData, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int          ncomp = 0, nfail = 0;

    mc_mem_if dut (
        .CLK(CLK), .Reset(Reset), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .Funct3(Funct3), .PC(PC), .Result(Result), .WriteData(WriteData),
        .Stall(Stall), .Instr(Instr), .OldPC(OldPC), .ReadData(ReadData),
        .MisalignErr(MisalignErr), .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        logic [2:0]  f3;
        logic        adrsrc;
        logic [31:0] pc, res, wd, rdata;
        int          waitn;
        logic        mis;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stalls;
        logic [31:0] instr, oldpc, rd;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncomp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drop_strobes();
        IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic run(input int idx, input vec_t v);
        int stalls = 0, reqs = 0;
        bit done = 0, seen = 0, mis = 0;
        @(negedge CLK);
        IRWrite = v.kind == 0; MemRead = v.kind == 1; MemWrite = v.kind == 2;
        AdrSrc = v.adrsrc; Funct3 = v.f3; PC = v.pc; Result = v.res;
        WriteData = v.wd; mem_rdata = v.rdata; mem_ack = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (mem_req) begin
                if (!seen) begin
                    seen = 1;
                    chk($sformatf("v%0d addr", idx), mem_addr, v.addr);
                    chk($sformatf("v%0d we", idx), {31'b0, mem_we}, {31'b0, v.kind == 2});
                    chk($sformatf("v%0d be", idx), {28'b0, mem_be}, {28'b0, v.be});
                    if (v.kind == 2) chk($sformatf("v%0d wdata", idx), mem_wdata, v.wdata);
                end
                mem_ack = (reqs == v.waitn);
                reqs++;
            end else begin
                mem_ack = 1'b0;
            end
            if (!Stall) begin
                done = 1;
                mis = MisalignErr;
                drop_strobes();
            end else begin
                stalls++;
                @(negedge CLK);
            end
        end
        if (!done) begin
            drop_strobes();
            chk($sformatf("v%0d completion", idx), 32'd0, 32'd1);
        end
        chk($sformatf("v%0d stall cycles", idx), stalls, v.stalls);
        chk($sformatf("v%0d bus cycle seen", idx), {31'b0, seen}, {31'b0, ~v.mis});
        chk($sformatf("v%0d misalign pulse", idx), {31'b0, mis}, {31'b0, v.mis});
        chk($sformatf("v%0d Instr", idx), Instr, v.instr);
        chk($sformatf("v%0d OldPC", idx), OldPC, v.oldpc);
        chk($sformatf("v%0d ReadData", idx), ReadData, v.rd);
        @(negedge CLK);
        chk($sformatf("v%0d misalign cleared", idx), {31'b0, MisalignErr}, 32'd0);
    endtask

    initial begin
        int reqs, stalls;
        //        kind f3    as  pc       res      wd            rdata         wt mis addr     be     wdata         st instr         oldpc    rd
        vecs[0]  = '{0, 3'd0, 0, 32'h100, 32'h0,    32'h0,        32'h00500093, 0, 0, 32'h100,  4'hf, 32'h0,        2, 32'h00500093, 32'h100, 32'h0};
        vecs[1]  = '{1, 3'd0, 1, 32'h104, 32'h203,  32'h0,        32'h80FFFFFF, 2, 0, 32'h200,  4'hf, 32'h0,        4, 32'h00500093, 32'h100, 32'hFFFFFF80};
        vecs[2]  = '{2, 3'd1, 1, 32'h104, 32'h1002, 32'h0000BEEF, 32'h0,        0, 0, 32'h1000, 4'hc, 32'hBEEFBEEF, 2, 32'h00500093, 32'h100, 32'hFFFFFF80};
        vecs[3]  = '{2, 3'd2, 1, 32'h104, 32'h1001, 32'h0,        32'h0,        0, 1, 32'h0,    4'h0, 32'h0,        1, 32'h00500093, 32'h100, 32'hFFFFFF80};
        vecs[4]  = '{1, 3'd5, 1, 32'h104, 32'h302,  32'h0,        32'h80017FFF, 1, 0, 32'h300,  4'hf, 32'h0,        3, 32'h00500093, 32'h100, 32'h00008001};
        vecs[5]  = '{1, 3'd1, 1, 32'h104, 32'h300,  32'h0,        32'h12348001, 0, 0, 32'h300,  4'hf, 32'h0,        2, 32'h00500093, 32'h100, 32'hFFFF8001};
        vecs[6]  = '{1, 3'd4, 1, 32'h104, 32'h401,  32'h0,        32'h11228344, 0, 0, 32'h400,  4'hf, 32'h0,        2, 32'h00500093, 32'h100, 32'h00000083};
        vecs[7]  = '{2, 3'd0, 1, 32'h104, 32'h2003, 32'h123456AB, 32'h0,        0, 0, 32'h2000, 4'h8, 32'hABABABAB, 2, 32'h00500093, 32'h100, 32'h00000083};
        vecs[8]  = '{1, 3'd2, 1, 32'h104, 32'h500,  32'h0,        32'hDEADBEEF, 0, 0, 32'h500,  4'hf, 32'h0,        2, 32'h00500093, 32'h100, 32'hDEADBEEF};
        vecs[9]  = '{1, 3'd1, 1, 32'h104, 32'h501,  32'h0,        32'h0,        0, 1, 32'h0,    4'h0, 32'h0,        1, 32'h00500093, 32'h100, 32'hDEADBEEF};
        vecs[10] = '{0, 3'd0, 0, 32'h102, 32'h0,    32'h0,        32'h0,        0, 1, 32'h0,    4'h0, 32'h0,        1, 32'h00500093, 32'h100, 32'hDEADBEEF};
        vecs[11] = '{1, 3'd2, 0, 32'h600, 32'h999,  32'h0,        32'hCAFEF00D, 0, 0, 32'h600,  4'hf, 32'h0,        2, 32'h00500093, 32'h100, 32'hCAFEF00D};
        vecs[12] = '{0, 3'd0, 0, 32'h104, 32'h0,    32'h0,        32'h00000513, 1, 0, 32'h104,  4'hf, 32'h0,        3, 32'h00000513, 32'h104, 32'hCAFEF00D};
        vecs[13] = '{2, 3'd7, 1, 32'h104, 32'h700,  32'h01020304, 32'h0,        0, 0, 32'h700,  4'hf, 32'h01020304, 2, 32'h00000513, 32'h104, 32'hCAFEF00D};
        vecs[14] = '{1, 3'd6, 1, 32'h104, 32'h704,  32'h0,        32'hA5A50001, 3, 0, 32'h704,  4'hf, 32'h0,        5, 32'h00000513, 32'h104, 32'hA5A50001};

        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        chk("reset Instr", Instr, 32'h00000013);
        chk("reset OldPC", OldPC, 32'h0);
        chk("reset ReadData", ReadData, 32'h0);
        chk("reset mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset mem_we", {31'b0, mem_we}, 32'd0);
        chk("reset mem_be", {28'b0, mem_be}, 32'd0);
        chk("reset BusErr", {31'b0, BusErr}, 32'd0);
        chk("reset MisalignErr", {31'b0, MisalignErr}, 32'd0);
        chk("reset Stall", {31'b0, Stall}, 32'd0);

        for (int i = 0; i < 15; i++) run(i, vecs[i]);

        // Fetch that is never acknowledged must abort after TIMEOUT request cycles.
        @(negedge CLK);
        IRWrite = 1'b1; PC = 32'h800; mem_rdata = 32'hFFFFFFFF;
        reqs = 0; stalls = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (mem_req) reqs++;
            if (!Stall) break;
            stalls++;
            @(negedge CLK);
        end
        drop_strobes();
        chk("timeout req cycles", reqs, 16);
        chk("timeout stall cycles", stalls, 17);
        chk("timeout BusErr", {31'b0, BusErr}, 32'd1);
        chk("timeout Instr kept", Instr, 32'h00000513);
        repeat (3) @(negedge CLK);
        chk("BusErr sticky", {31'b0, BusErr}, 32'd1);
        chk("timeout req dropped", {31'b0, mem_req}, 32'd0);

        // Reset while BUSY, followed by a late acknowledge.
        @(negedge CLK);
        IRWrite = 1'b1; PC = 32'h900;
        @(negedge CLK);
        #1;
        chk("rst seq req up", {31'b0, mem_req}, 32'd1);
        Reset = 1'b1;
        drop_strobes();
        @(negedge CLK);
        chk("rst seq req dropped", {31'b0, mem_req}, 32'd0);
        Reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        repeat (3) @(negedge CLK);
        chk("rst seq req idle", {31'b0, mem_req}, 32'd0);
        chk("rst seq Instr", Instr, 32'h00000013);
        chk("rst seq OldPC", OldPC, 32'h0);
        chk("rst seq BusErr cleared", {31'b0, BusErr}, 32'd0);
        chk("rst seq Stall", {31'b0, Stall}, 32'd0);
        mem_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
